// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package rf_pkg;

    localparam int RF_DW  = 8;
    localparam int RF_RFW = 2;

    localparam logic [RF_RFW-1:0] REG_ZERO = {RF_RFW{1'b0}};

    // Which requester won the most recent completed handshake.
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer is kept by the parent.
import rf_pkg::*;

module rr_arb2 (
    input  logic       a_valid,
    input  logic       b_valid,
    input  grant_t     last_grant,
    output logic [1:0] grant
);

    // A lone requester always wins; on a tie the port that did not win last time goes.
    always_comb begin
        grant    = 2'b00;
        grant[0] = a_valid & (~b_valid | (last_grant == GRANT_B));
        grant[1] = b_valid & (~a_valid | (last_grant == GRANT_A));
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port between the ALU (A) and load (B) paths,
// registers the winning write for one cycle and exposes hazard/bypass information.
import rf_pkg::*;

module rf_wb_arbiter #(
    parameter int DW  = RF_DW,
    parameter int RFW = RF_RFW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           a_valid,
    output logic           a_ready,
    input  logic [RFW-1:0] a_addr,
    input  logic [DW-1:0]  a_data,
    input  logic           b_valid,
    output logic           b_ready,
    input  logic [RFW-1:0] b_addr,
    input  logic [DW-1:0]  b_data,
    output logic           rf_we,
    output logic [RFW-1:0] rf_wr_address,
    output logic [DW-1:0]  rf_wr_data,
    input  logic [RFW-1:0] rr1_address,
    input  logic [RFW-1:0] rr2_address,
    output logic           rr1_pending,
    output logic           rr2_pending,
    output logic [DW-1:0]  fwd_data
);

    grant_t         last_grant;
    logic [1:0]     grant;
    logic           hs_a;
    logic           hs_b;
    logic           out_valid;
    logic [RFW-1:0] out_addr;
    logic [DW-1:0]  out_data;

    rr_arb2 u_arb (
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Readies are withheld while reset is asserted so no handshake can complete then.
    always_comb begin
        a_ready = rst_n & grant[0];
        b_ready = rst_n & grant[1];
        hs_a    = a_valid & a_ready;
        hs_b    = b_valid & b_ready;
    end

    // Pointer and write stage; a zero-register request takes its turn but never writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= GRANT_B;
            out_valid  <= 1'b0;
            out_addr   <= REG_ZERO;
            out_data   <= '0;
        end else if (hs_a) begin
            last_grant <= GRANT_A;
            out_valid  <= (a_addr != REG_ZERO);
            out_addr   <= a_addr;
            out_data   <= a_data;
        end else if (hs_b) begin
            last_grant <= GRANT_B;
            out_valid  <= (b_addr != REG_ZERO);
            out_addr   <= b_addr;
            out_data   <= b_data;
        end else begin
            out_valid  <= 1'b0;
        end
    end

    // RF port, read-after-write hazard flags and bypass data from the pending write.
    always_comb begin
        rf_we         = out_valid;
        rf_wr_address = out_addr;
        rf_wr_data    = out_data;
        rr1_pending   = out_valid & (out_addr != REG_ZERO) & (out_addr == rr1_address);
        rr2_pending   = out_valid & (out_addr != REG_ZERO) & (out_addr == rr2_address);
        fwd_data      = out_valid ? out_data : '0;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter against a transaction-level model.
module tb_rf_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, a_ready, b_valid, b_ready;
    logic [1:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       rf_we;
    logic [1:0] rf_wr_address;
    logic [7:0] rf_wr_data;
    logic [1:0] rr1_address, rr2_address;
    logic       rr1_pending, rr2_pending;
    logic [7:0] fwd_data;

    int tests_run = 0;
    int tests_failed = 0;

    // Pending requests per port, each entry is {addr, data}.
    logic [9:0] a_q[$];
    logic [9:0] b_q[$];

    // Model: who won last, the write expected on the port next, and the RF contents.
    int         m_last;
    logic       m_we;
    logic [1:0] m_addr;
    logic [7:0] m_data;
    logic [7:0] exp_rf[4];
    logic [7:0] dut_rf[4];

    rf_wb_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .a_addr        (a_addr),
        .a_data        (a_data),
        .b_valid       (b_valid),
        .b_ready       (b_ready),
        .b_addr        (b_addr),
        .b_data        (b_data),
        .rf_we         (rf_we),
        .rf_wr_address (rf_wr_address),
        .rf_wr_data    (rf_wr_data),
        .rr1_address   (rr1_address),
        .rr2_address   (rr2_address),
        .rr1_pending   (rr1_pending),
        .rr2_pending   (rr2_pending),
        .fwd_data      (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: present the queue heads, check at the negedge, advance the model at the posedge.
    task automatic applyStimulus(input logic rst_val, input logic [1:0] rr1, input logic [1:0] rr2);
        logic exp_a, exp_b;
        rst_n       = rst_val;
        rr1_address = rr1;
        rr2_address = rr2;
        a_valid     = (a_q.size() > 0);
        b_valid     = (b_q.size() > 0);
        if (a_valid) {a_addr, a_data} = a_q[0];
        if (b_valid) {b_addr, b_data} = b_q[0];

        @(negedge clk);
        exp_a = rst_n && a_valid && (!b_valid || m_last == 1);
        exp_b = rst_n && b_valid && (!a_valid || m_last == 0);
        checkOutput("a_ready", 32'(a_ready), 32'(exp_a));
        checkOutput("b_ready", 32'(b_ready), 32'(exp_b));
        checkOutput("rf_we", 32'(rf_we), 32'(m_we));
        checkOutput("rf_wr_address", 32'(rf_wr_address), 32'(m_addr));
        checkOutput("rf_wr_data", 32'(rf_wr_data), 32'(m_data));
        checkOutput("rr1_pending", 32'(rr1_pending), 32'(m_we && m_addr != 0 && m_addr == rr1));
        checkOutput("rr2_pending", 32'(rr2_pending), 32'(m_we && m_addr != 0 && m_addr == rr2));
        checkOutput("fwd_data", 32'(fwd_data), m_we ? 32'(m_data) : 32'd0);

        if (rf_we && rf_wr_address != 2'd0) dut_rf[rf_wr_address] = rf_wr_data;
        if (m_we) exp_rf[m_addr] = m_data;
        checkOutput("rf_contents", {dut_rf[3], dut_rf[2], dut_rf[1], dut_rf[0]},
                    {exp_rf[3], exp_rf[2], exp_rf[1], exp_rf[0]});

        @(posedge clk);
        if (!rst_n) begin
            m_last = 1;
            m_we   = 1'b0;
            m_addr = 2'd0;
            m_data = 8'd0;
        end else if (exp_a) begin
            m_last = 0;
            m_we   = (a_addr != 2'd0);
            m_addr = a_addr;
            m_data = a_data;
            void'(a_q.pop_front());
        end else if (exp_b) begin
            m_last = 1;
            m_we   = (b_addr != 2'd0);
            m_addr = b_addr;
            m_data = b_data;
            void'(b_q.pop_front());
        end else begin
            m_we = 1'b0;
        end
        #1;
    endtask

    initial begin
        m_last = 1;
        m_we   = 1'b0;
        m_addr = 2'd0;
        m_data = 8'd0;
        for (int i = 0; i < 4; i++) begin
            exp_rf[i] = 8'd0;
            dut_rf[i] = 8'd0;
        end
        a_addr = 2'd0; a_data = 8'd0; b_addr = 2'd0; b_data = 8'd0;

        // Reset with both requesters active, then A wins the first tie.
        a_q.push_back({2'd1, 8'hA1});
        b_q.push_back({2'd2, 8'hB2});
        applyStimulus(1'b0, 2'd0, 2'd0);
        applyStimulus(1'b0, 2'd0, 2'd0);
        applyStimulus(1'b1, 2'd1, 2'd2);
        applyStimulus(1'b1, 2'd1, 2'd2);
        applyStimulus(1'b1, 2'd2, 2'd1);

        // Single A write to register 2.
        a_q.push_back({2'd2, 8'h5A});
        applyStimulus(1'b1, 2'd2, 2'd0);
        applyStimulus(1'b1, 2'd2, 2'd0);
        applyStimulus(1'b1, 2'd0, 2'd0);

        // Lone B write leaves the pointer on B, then both ports alternate.
        b_q.push_back({2'd1, 8'h00});
        applyStimulus(1'b1, 2'd0, 2'd0);
        a_q.push_back({2'd1, 8'h11}); a_q.push_back({2'd1, 8'h12});
        b_q.push_back({2'd3, 8'h31}); b_q.push_back({2'd3, 8'h32});
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'd1, 2'd3);

        // Zero register is accepted but never written.
        a_q.push_back({2'd0, 8'hFF});
        applyStimulus(1'b1, 2'd0, 2'd0);
        applyStimulus(1'b1, 2'd0, 2'd0);

        // Hazard detection and bypass.
        a_q.push_back({2'd3, 8'h77});
        applyStimulus(1'b1, 2'd3, 2'd1);
        applyStimulus(1'b1, 2'd3, 2'd1);

        // Same address from both ports: later grant wins in the RF.
        a_q.push_back({2'd2, 8'hC1});
        b_q.push_back({2'd2, 8'hC2});
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd2, 2'd2);

        // Handshake followed by reset; pointer returns to B.
        a_q.push_back({2'd1, 8'h99});
        applyStimulus(1'b1, 2'd1, 2'd0);
        applyStimulus(1'b0, 2'd1, 2'd0);
        applyStimulus(1'b1, 2'd1, 2'd0);
        a_q.push_back({2'd3, 8'h44});
        b_q.push_back({2'd3, 8'h55});
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd3, 2'd0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            if (a_q.size() < 2 && $urandom_range(0, 99) < 60)
                a_q.push_back(10'($urandom));
            if (b_q.size() < 2 && $urandom_range(0, 99) < 60)
                b_q.push_back(10'($urandom));
            applyStimulus(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
                          2'($urandom), 2'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
